// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM/LUI issue front end for the clocked alu block.
// Optional: define ALU_ISSUE_BYPASS_EN to forward the last writeback into operands.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_dout,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
  localparam logic [OPW-1:0] ALU_SLL  = OPW'(2);
  localparam logic [OPW-1:0] ALU_SLT  = OPW'(3);
  localparam logic [OPW-1:0] ALU_SLTU = OPW'(4);
  localparam logic [OPW-1:0] ALU_XOR  = OPW'(5);
  localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
  localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
  localparam logic [OPW-1:0] ALU_OR   = OPW'(8);
  localparam logic [OPW-1:0] ALU_AND  = OPW'(9);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t      r_state;
  logic [31:0] r_instr;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [OPW-1:0]  w_f3_op;
  logic [OPW-1:0]  w_op;
  logic            w_illegal;
  logic            w_use_imm;
  logic            w_lui;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_raw;
  logic [XLEN-1:0] w_rs2_raw;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_opcode = r_instr[6:0];
  assign w_f3     = r_instr[14:12];
  assign w_f7     = r_instr[31:25];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_instr <= instr;
          r_state <= S_READ;
        end
        S_READ:  r_state <= w_illegal ? S_IDLE : S_EXEC;
        S_EXEC:  r_state <= S_WB;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (w_f3)
      3'b000:  w_f3_op = ALU_ADD;
      3'b001:  w_f3_op = ALU_SLL;
      3'b010:  w_f3_op = ALU_SLT;
      3'b011:  w_f3_op = ALU_SLTU;
      3'b100:  w_f3_op = ALU_XOR;
      3'b101:  w_f3_op = ALU_SRL;
      3'b110:  w_f3_op = ALU_OR;
      default: w_f3_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_illegal = 1'b0;
    w_use_imm = 1'b0;
    w_lui     = 1'b0;
    w_op      = ALU_ADD;
    w_imm     = XLEN'($signed(r_instr[31:20]));
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == 7'b0000000)
          w_op = w_f3_op;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
          w_op = ALU_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
          w_op = ALU_SRA;
        else
          w_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        w_use_imm = 1'b1;
        w_op      = w_f3_op;
        // Shift-immediates take a zero-extended shamt; funct7 selects arithmetic right.
        if (w_f3 == 3'b001) begin
          w_imm = XLEN'(r_instr[24:20]);
          if (w_f7 != 7'b0000000) w_illegal = 1'b1;
        end else if (w_f3 == 3'b101) begin
          w_imm = XLEN'(r_instr[24:20]);
          if (w_f7 == 7'b0100000)
            w_op = ALU_SRA;
          else if (w_f7 != 7'b0000000)
            w_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        w_lui     = 1'b1;
        w_use_imm = 1'b1;
        w_imm     = XLEN'($signed({r_instr[31:12], 12'b0}));
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rs1_raw = (w_rs1 == 5'd0) ? '0 : rf_rs1_data;
  assign w_rs2_raw = (w_rs2 == 5'd0) ? '0 : rf_rs2_data;

`ifdef ALU_ISSUE_BYPASS_EN
  logic            r_byp_valid;
  logic [4:0]      r_byp_rd;
  logic [XLEN-1:0] r_byp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_valid <= 1'b0;
      r_byp_rd    <= '0;
      r_byp_data  <= '0;
    end else if (r_state == S_WB && r_instr[11:7] != 5'd0) begin
      r_byp_valid <= 1'b1;
      r_byp_rd    <= r_instr[11:7];
      r_byp_data  <= alu_dout;
    end
  end

  assign w_rs1_val = (r_byp_valid && w_rs1 != 5'd0 && w_rs1 == r_byp_rd) ? r_byp_data : w_rs1_raw;
  assign w_rs2_val = (r_byp_valid && w_rs2 != 5'd0 && w_rs2 == r_byp_rd) ? r_byp_data : w_rs2_raw;
`else
  assign w_rs1_val = w_rs1_raw;
  assign w_rs2_val = w_rs2_raw;
`endif

  // State resets asynchronously to IDLE, so gating in_ready with rst keeps every output low in reset.
  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign rf_rs1_addr = (r_state == S_READ) ? w_rs1 : 5'd0;
  assign rf_rs2_addr = (r_state == S_READ) ? w_rs2 : 5'd0;
  assign illegal     = (r_state == S_READ) && w_illegal;

  assign alu_d1 = (r_state == S_EXEC && !w_lui) ? w_rs1_val : '0;
  assign alu_d2 = (r_state == S_EXEC) ? (w_use_imm ? w_imm : w_rs2_val) : '0;
  assign alu_op = (r_state == S_EXEC) ? w_op : '0;

  assign wb_valid = (r_state == S_WB);
  assign wb_rd    = (r_state == S_WB) ? r_instr[11:7] : 5'd0;
  assign wb_data  = (r_state == S_WB) ? alu_dout : '0;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with rf and alu stubs.
module tb_alu_issue;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
  localparam logic [3:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [31:0] alu_d1, alu_d2, alu_dout;
  logic [3:0]  alu_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_op(alu_op), .alu_dout(alu_dout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
  );

  logic [31:0] rf_mem [32];

  always @(posedge clk) begin
    rf_rs1_data <= rf_mem[rf_rs1_addr];
    rf_rs2_data <= rf_mem[rf_rs2_addr];
  end

  always @(posedge clk) begin
    case (alu_op)
      ADD:     alu_dout <= alu_d1 + alu_d2;
      SUB:     alu_dout <= alu_d1 - alu_d2;
      SLL:     alu_dout <= alu_d1 << alu_d2[4:0];
      SLT:     alu_dout <= ($signed(alu_d1) < $signed(alu_d2)) ? 32'd1 : 32'd0;
      SLTU:    alu_dout <= (alu_d1 < alu_d2) ? 32'd1 : 32'd0;
      XOR:     alu_dout <= alu_d1 ^ alu_d2;
      SRL:     alu_dout <= alu_d1 >> alu_d2[4:0];
      SRA:     alu_dout <= $signed(alu_d1) >>> alu_d2[4:0];
      OR:      alu_dout <= alu_d1 | alu_d2;
      AND:     alu_dout <= alu_d1 & alu_d2;
      default: alu_dout <= 32'hBAD0BAD0;
    endcase
  end

  int tests_run = 0;
  int tests_failed = 0;

  bit          r_accepted;
  int          r_lat, r_ill_at, r_wb_cnt;
  logic [31:0] r_data, r_d1, r_d2;
  logic [4:0]  r_rd, r_a1;
  logic [3:0]  r_op;
  logic        r_ready2;

  // Issue one instruction and observe the five negedges that follow the accept edge.
  task automatic run_instr(input logic [31:0] ins);
    r_accepted = 0; r_lat = 0; r_ill_at = 0; r_wb_cnt = 0;
    r_data = 'x; r_rd = 'x; r_d1 = 'x; r_d2 = 'x; r_op = 'x; r_a1 = 'x; r_ready2 = 1'bx;
    @(negedge clk);
    in_valid = 1'b1;
    instr = ins;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin r_accepted = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    instr = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) r_a1 = rf_rs1_addr;
      if (i == 2) begin r_op = alu_op; r_d1 = alu_d1; r_d2 = alu_d2; r_ready2 = in_ready; end
      if (illegal && r_ill_at == 0) r_ill_at = i;
      if (wb_valid) begin
        r_wb_cnt++;
        if (r_lat == 0) r_lat = i;
        r_data = wb_data;
        r_rd = wb_rd;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests_run++; if ({wb_valid, illegal, wb_rd, wb_data} !== '0) begin tests_failed++; $display("FAIL reset_wb got v=%b ill=%b rd=%0d d=%h exp 0", wb_valid, illegal, wb_rd, wb_data); end
    tests_run++; if ({alu_d1, alu_d2, alu_op, rf_rs1_addr, rf_rs2_addr} !== '0) begin tests_failed++; $display("FAIL reset_alu_rf got d1=%h d2=%h op=%0d exp 0", alu_d1, alu_d2, alu_op); end
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_srli();
    run_instr(32'h0010D193);
    tests_run++; if (!r_accepted) begin tests_failed++; $display("FAIL srli_accept got none exp accept within 8 cycles"); end
    tests_run++; if (r_a1 !== 5'd1) begin tests_failed++; $display("FAIL srli_rs1_addr got %0d exp 1", r_a1); end
    tests_run++; if (r_op !== SRL || r_d1 !== 32'hFFFFFFF6 || r_d2 !== 32'd1) begin tests_failed++; $display("FAIL srli_exec got op=%0d d1=%h d2=%h exp op=%0d d1=fffffff6 d2=1", r_op, r_d1, r_d2, SRL); end
    tests_run++; if (r_lat !== 3 || r_wb_cnt !== 1) begin tests_failed++; $display("FAIL srli_latency got lat=%0d cnt=%0d exp lat=3 cnt=1", r_lat, r_wb_cnt); end
    tests_run++; if (r_rd !== 5'd3 || r_data !== 32'h7FFFFFFB) begin tests_failed++; $display("FAIL srli_wb got rd=%0d d=%h exp rd=3 d=7ffffffb", r_rd, r_data); end
  endtask

  task automatic test_srai();
    run_instr(32'h4010D193);
    tests_run++; if (r_op !== SRA) begin tests_failed++; $display("FAIL srai_op got %0d exp %0d", r_op, SRA); end
    tests_run++; if (r_data !== 32'hFFFFFFFB || r_rd !== 5'd3) begin tests_failed++; $display("FAIL srai_wb got rd=%0d d=%h exp rd=3 d=fffffffb", r_rd, r_data); end
  endtask

  task automatic test_op_table();
    logic [31:0] ins [6]  = '{32'h002081B3, 32'h402081B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3, 32'h12345237};
    logic [31:0] expd [6] = '{32'hFFFFFFFB, 32'hFFFFFFF1, 32'h00000001, 32'h00000000, 32'hFFFFFFF3, 32'h12345000};
    logic [4:0]  exrd [6] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4};
    for (int k = 0; k < 6; k++) begin
      run_instr(ins[k]);
      tests_run++; if (r_wb_cnt !== 1 || r_data !== expd[k] || r_rd !== exrd[k]) begin tests_failed++; $display("FAIL op_table[%0d] got cnt=%0d rd=%0d d=%h exp cnt=1 rd=%0d d=%h", k, r_wb_cnt, r_rd, r_data, exrd[k], expd[k]); end
    end
  endtask

  task automatic test_addi_x0();
    run_instr(32'hFFF00113);
    tests_run++; if (r_data !== 32'hFFFFFFFF || r_rd !== 5'd2) begin tests_failed++; $display("FAIL addi_x0 got rd=%0d d=%h exp rd=2 d=ffffffff", r_rd, r_data); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] acc_mask = '0;
    int wbs = 0;
    @(negedge clk);
    in_valid = 1'b1;
    instr = 32'hFFF00113;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) acc_mask[i] = 1'b1;
      if (wb_valid) begin
        wbs++;
        if (wb_data !== 32'hFFFFFFFF) begin tests_run++; tests_failed++; $display("FAIL b2b_data got %h exp ffffffff", wb_data); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++; if (acc_mask !== 12'b0001_0001_0001) begin tests_failed++; $display("FAIL b2b_accepts got %b exp 000100010001", acc_mask); end
    tests_run++; if (wbs !== 3) begin tests_failed++; $display("FAIL b2b_wb_count got %0d exp 3", wbs); end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [4] = '{32'h00000000, 32'h40001033, 32'h40001013, 32'h02000033};
    for (int k = 0; k < 4; k++) begin
      run_instr(ins[k]);
      tests_run++; if (r_ill_at !== 1 || r_wb_cnt !== 0 || r_ready2 !== 1'b1) begin tests_failed++; $display("FAIL illegal[%0d] got ill_at=%0d wb=%0d ready=%b exp ill_at=1 wb=0 ready=1", k, r_ill_at, r_wb_cnt, r_ready2); end
    end
  endtask

  task automatic test_reset_abort();
    int wbs = 0;
    @(negedge clk);
    in_valid = 1'b1;
    instr = 32'hFFF00113;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (alu_op !== ADD || alu_d2 !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL abort_exec got op=%0d d2=%h exp op=0 d2=ffffffff", alu_op, alu_d2); end
    rst = 1'b1;
    #1;
    tests_run++; if ({in_ready, wb_valid, illegal, alu_d1, alu_d2, alu_op, rf_rs1_addr, rf_rs2_addr, wb_rd, wb_data} !== '0) begin tests_failed++; $display("FAIL abort_outputs got rdy=%b v=%b op=%0d d2=%h exp all 0", in_ready, wb_valid, alu_op, alu_d2); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (wb_valid) wbs++; end
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (wb_valid) wbs++; end
    tests_run++; if (wbs !== 0) begin tests_failed++; $display("FAIL abort_no_wb got %0d exp 0", wbs); end
    run_instr(32'h0010D193);
    tests_run++; if (r_lat !== 3 || r_data !== 32'h7FFFFFFB) begin tests_failed++; $display("FAIL abort_next got lat=%0d d=%h exp lat=3 d=7ffffffb", r_lat, r_data); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
`ifdef ALU_ISSUE_BYPASS_EN
    exp_d = 32'd14;
`else
    exp_d = 32'd0;
`endif
    run_instr(32'h00700293);
    tests_run++; if (r_data !== 32'd7 || r_rd !== 5'd5) begin tests_failed++; $display("FAIL bypass_first got rd=%0d d=%h exp rd=5 d=7", r_rd, r_data); end
    run_instr(32'h00528333);
    tests_run++; if (r_data !== exp_d || r_rd !== 5'd6) begin tests_failed++; $display("FAIL bypass_add got rd=%0d d=%h exp rd=6 d=%h", r_rd, r_data, exp_d); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rf_mem[0] = 32'h12345678;
    rf_mem[1] = 32'hFFFFFFF6;
    rf_mem[2] = 32'h00000005;
    rf_mem[5] = 32'h00000000;
    test_reset();
    test_srli();
    test_srai();
    test_op_table();
    test_addi_x0();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
